// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the pipelined MIPS core.
//   PC_W / INSTR_W   : word-address and instruction widths
//   NOP_INSTR        : sll $0,$0,0, used for bubbles and out-of-range fetches
//   if_id_t          : IF/ID pipeline register contents
//   IF_ID_BUBBLE     : the IF/ID value that carries no instruction
//   pc_sel_e         : next-PC source for pc_reg
//   fetch_action_e   : what the fetch stage does on the coming clock edge
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int PC_W    = 30;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus1;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    valid:    1'b0,
    instr:    NOP_INSTR,
    pc:       '0,
    pc_plus1: '0
  };

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD
  } pc_sel_e;

  typedef enum logic [2:0] {
    FETCH_LATCH,         // normal fetch into IF/ID
    FETCH_BUBBLE,        // shared port taken by MEM: insert a bubble, refetch
    FETCH_STALL,         // hazard stall: freeze everything
    FETCH_REDIR_SQUASH,  // redirect: squash branch+2 with a bubble
    FETCH_REDIR_KEEP     // redirect during stall: delay slot stays in IF/ID
  } fetch_action_e;

  // Priority: redirect > stall > shared-port conflict > normal fetch.
  function automatic fetch_action_e fetch_decide(input logic redirect,
                                                 input logic stall,
                                                 input logic busy);
    if (redirect) return stall ? FETCH_REDIR_KEEP : FETCH_REDIR_SQUASH;
    if (stall)    return FETCH_STALL;
    if (busy)     return FETCH_BUBBLE;
    return FETCH_LATCH;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Shared instruction/data memory port as seen by the fetch stage.
//   fetch_select : 1 = memory address comes from d_pc, 0 = from the data path
//   d_pc         : fetch word address
//   instr_in     : combinational read data for d_pc
//   mem_busy     : the memory stage owns the shared port this cycle
// master = fetch stage, slave = memory / arbitration side.
// -----------------------------------------------------------------------------
interface fetch_stage_if;
  import cpu_pkg::*;

  logic               fetch_select;
  logic [PC_W-1:0]    d_pc;
  logic [INSTR_W-1:0] instr_in;
  logic               mem_busy;

  modport master (
    output fetch_select,
    output d_pc,
    input  instr_in,
    input  mem_busy
  );

  modport slave (
    input  fetch_select,
    input  d_pc,
    output instr_in,
    output mem_busy
  );

endinterface

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter (word address) with next-PC select.
//   clk, rst : clock, asynchronous active-high reset (PC <= RESET_PC)
//   sel      : PC_HOLD keeps, PC_INC adds one (wraps at 2^30), PC_LOAD takes target
//   target   : redirect word address
//   pc       : current PC
// -----------------------------------------------------------------------------
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  pc_sel_e         sel,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_next;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    pc_next = pc;
    unique case (sel)
      PC_INC:  pc_next = pc + PC_W'(1);
      PC_LOAD: pc_next = target;
      default: pc_next = pc;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, drives the shared memory port and
// latches the fetched instruction into the IF/ID register.
//   clk, rst        : clock, asynchronous active-high reset
//   stall_in        : hazard stall, freezes PC and IF/ID
//   redirect_valid  : taken branch/jump from EX (single-cycle pulse)
//   redirect_pc     : its target word address
//   mem             : shared memory port (fetch_select, d_pc, instr_in, mem_busy)
//   if_id_*         : IF/ID register outputs
//   oob_fetch       : last latched fetch was at or beyond IMEM_DEPTH
//   perf_fetched    : valid instructions latched (wraps)
//   perf_bubbles    : bubbles inserted (wraps)
// -----------------------------------------------------------------------------
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 30'h0,
  parameter int unsigned     IMEM_DEPTH = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_in,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  fetch_stage_if.master      mem,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [PC_W-1:0]    if_id_pc_plus1,
  output logic               oob_fetch,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
);

  // One extra bit so a depth of 2^30 (whole address space) is representable.
  localparam logic [PC_W:0] DEPTH = IMEM_DEPTH[PC_W:0];

  logic [PC_W-1:0] pc;
  pc_sel_e         pc_sel;
  fetch_action_e   action;
  logic            in_range;
  if_id_t          fetched;
  if_id_t          if_id;

  // ---------------------------------------------------------------------------
  // Next-cycle decision
  // ---------------------------------------------------------------------------
  always_comb begin
    action = fetch_decide(redirect_valid, stall_in, mem.mem_busy);
    pc_sel = PC_HOLD;
    unique case (action)
      FETCH_LATCH:                          pc_sel = PC_INC;
      FETCH_REDIR_SQUASH, FETCH_REDIR_KEEP: pc_sel = PC_LOAD;
      default:                              pc_sel = PC_HOLD;
    endcase
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .sel    (pc_sel),
    .target (redirect_pc),
    .pc     (pc)
  );

  // ---------------------------------------------------------------------------
  // Memory port and effective instruction
  // ---------------------------------------------------------------------------
  assign mem.d_pc         = pc;
  assign mem.fetch_select = ~mem.mem_busy;

  assign in_range = ({1'b0, pc} < DEPTH);

  always_comb begin
    fetched          = IF_ID_BUBBLE;
    fetched.valid    = 1'b1;
    fetched.instr    = in_range ? mem.instr_in : NOP_INSTR;
    fetched.pc       = pc;
    fetched.pc_plus1 = pc + PC_W'(1);
  end

  // ---------------------------------------------------------------------------
  // IF/ID register, out-of-range flag and performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id        <= IF_ID_BUBBLE;
      oob_fetch    <= 1'b0;
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      unique case (action)
        FETCH_LATCH: begin
          if_id        <= fetched;
          oob_fetch    <= ~in_range;
          perf_fetched <= perf_fetched + 32'd1;
        end
        FETCH_BUBBLE, FETCH_REDIR_SQUASH: begin
          if_id        <= IF_ID_BUBBLE;
          perf_bubbles <= perf_bubbles + 32'd1;
        end
        default: ;  // stall or redirect-under-stall: IF/ID and counters hold
      endcase
    end
  end

  assign if_id_valid    = if_id.valid;
  assign if_id_instr    = if_id.instr;
  assign if_id_pc       = if_id.pc;
  assign if_id_pc_plus1 = if_id.pc_plus1;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage with a 32-word memory model. Word 31 holds a
// non-zero pattern so an out-of-range fetch must be forced to NOP by the DUT.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
  import cpu_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               stall_in;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               if_id_valid;
  logic [INSTR_W-1:0] if_id_instr;
  logic [PC_W-1:0]    if_id_pc;
  logic [PC_W-1:0]    if_id_pc_plus1;
  logic               oob_fetch;
  logic [31:0]        perf_fetched;
  logic [31:0]        perf_bubbles;

  logic [INSTR_W-1:0] mem_words [32];

  int tests_run = 0;
  int tests_failed = 0;

  fetch_stage_if mem_if ();

  fetch_stage #(
    .RESET_PC   (30'h0),
    .IMEM_DEPTH (31)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem            (mem_if.master),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .oob_fetch      (oob_fetch),
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
  );

  always #5 clk = ~clk;

  // Combinational memory: words 0..31 from the table, anything above is garbage.
  assign mem_if.instr_in = (mem_if.d_pc < 30'd32) ? mem_words[mem_if.d_pc[4:0]]
                                                  : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_latch(input string tag, input logic [PC_W-1:0] pc,
                             input logic [INSTR_W-1:0] instr);
    check({tag, ".valid"}, 64'(if_id_valid), 64'd1);
    check({tag, ".pc"},    64'(if_id_pc),    64'(pc));
    check({tag, ".instr"}, 64'(if_id_instr), 64'(instr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem_words[i] = 32'h2400_0000 | 32'(i);
    mem_words[0]  = 32'h2402_0005;
    mem_words[1]  = 32'h2403_0007;
    mem_words[2]  = 32'h2404_0002;
    mem_words[3]  = 32'h2405_0003;
    mem_words[6]  = 32'h0062_3824;
    mem_words[31] = 32'hCAFE_F00D;

    rst            = 1'b1;
    stall_in       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_if.mem_busy = 1'b0;
    #12;
    check("reset.d_pc",     64'(mem_if.d_pc),   64'd0);
    check("reset.valid",    64'(if_id_valid),   64'd0);
    check("reset.instr",    64'(if_id_instr),   64'd0);
    check("reset.oob",      64'(oob_fetch),     64'd0);
    check("reset.fetched",  64'(perf_fetched),  64'd0);
    check("reset.bubbles",  64'(perf_bubbles),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Straight-line fetch of words 0..3.
    tick(); check_latch("run0", 30'd0, 32'h2402_0005);
    check("run0.pc_plus1", 64'(if_id_pc_plus1), 64'd1);
    tick(); check_latch("run1", 30'd1, 32'h2403_0007);
    tick(); check_latch("run2", 30'd2, 32'h2404_0002);
    tick(); check_latch("run3", 30'd3, 32'h2405_0003);
    check("run.fetched4", 64'(perf_fetched), 64'd4);
    check("run.d_pc4",    64'(mem_if.d_pc),  64'd4);
    tick(); check_latch("run4", 30'd4, 32'h2400_0004);

    // Shared port busy for two cycles at PC = 5.
    mem_if.mem_busy = 1'b1;
    #1 check("busy.select", 64'(mem_if.fetch_select), 64'd0);
    tick();
    check("busy1.valid",   64'(if_id_valid),         64'd0);
    check("busy1.d_pc",    64'(mem_if.d_pc),         64'd5);
    check("busy1.select",  64'(mem_if.fetch_select), 64'd0);
    tick();
    check("busy2.valid",   64'(if_id_valid),  64'd0);
    check("busy2.d_pc",    64'(mem_if.d_pc),  64'd5);
    check("busy2.bubbles", 64'(perf_bubbles), 64'd2);
    mem_if.mem_busy = 1'b0;
    #1 check("busy.select_back", 64'(mem_if.fetch_select), 64'd1);
    tick(); check_latch("refetch5", 30'd5, 32'h2400_0005);
    tick(); check_latch("fetch6", 30'd6, 32'h0062_3824);
    check("fetch6.fetched", 64'(perf_fetched), 64'd7);

    // Hazard stall for three cycles with pc 6 in IF/ID.
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_latch("stall", 30'd6, 32'h0062_3824);
      check("stall.d_pc",    64'(mem_if.d_pc),  64'd7);
      check("stall.fetched", 64'(perf_fetched), 64'd7);
      check("stall.bubbles", 64'(perf_bubbles), 64'd2);
    end
    stall_in = 1'b0;
    tick(); check_latch("fetch7", 30'd7, 32'h2400_0007);
    tick(); check_latch("slot8", 30'd8, 32'h2400_0008);
    check("slot8.d_pc", 64'(mem_if.d_pc), 64'd9);

    // Redirect to 2 while PC = 9: branch+2 squashed, delay slot already latched.
    redirect_valid = 1'b1;
    redirect_pc    = 30'd2;
    tick();
    redirect_valid = 1'b0;
    check("redir.valid",   64'(if_id_valid),  64'd0);
    check("redir.instr",   64'(if_id_instr),  64'd0);
    check("redir.pc",      64'(if_id_pc),     64'd0);
    check("redir.d_pc",    64'(mem_if.d_pc),  64'd2);
    check("redir.bubbles", 64'(perf_bubbles), 64'd3);
    tick(); check_latch("target2", 30'd2, 32'h2404_0002);
    check("target2.fetched", 64'(perf_fetched), 64'd10);

    // Redirect under stall: PC takes the target, IF/ID and counters hold.
    redirect_valid = 1'b1;
    redirect_pc    = 30'd20;
    stall_in       = 1'b1;
    tick();
    redirect_valid = 1'b0;
    stall_in       = 1'b0;
    check("redir_stall.d_pc", 64'(mem_if.d_pc), 64'd20);
    check_latch("redir_stall", 30'd2, 32'h2404_0002);
    check("redir_stall.bubbles", 64'(perf_bubbles), 64'd3);
    check("redir_stall.fetched", 64'(perf_fetched), 64'd10);

    // Run 20..30, then fetch PC 31 which is out of range.
    for (int i = 20; i <= 30; i++) tick();
    check_latch("last_valid", 30'd30, 32'h2400_001E);
    check("last_valid.oob",  64'(oob_fetch),    64'd0);
    check("last_valid.d_pc", 64'(mem_if.d_pc),  64'd31);
    tick(); check_latch("oob31", 30'd31, 32'h0);
    check("oob31.flag",     64'(oob_fetch),      64'd1);
    check("oob31.pc_plus1", 64'(if_id_pc_plus1), 64'd32);
    check("oob31.fetched",  64'(perf_fetched),   64'd22);

    // Bubble keeps oob_fetch; then async reset between edges.
    mem_if.mem_busy = 1'b1;
    tick();
    check("oob_hold.flag",  64'(oob_fetch),    64'd1);
    check("oob_hold.valid", 64'(if_id_valid),  64'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst.d_pc",    64'(mem_if.d_pc),  64'd0);
    check("async_rst.valid",   64'(if_id_valid),  64'd0);
    check("async_rst.fetched", 64'(perf_fetched), 64'd0);
    check("async_rst.bubbles", 64'(perf_bubbles), 64'd0);
    check("async_rst.oob",     64'(oob_fetch),    64'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_if.mem_busy = 1'b0;

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 30'h3FFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    check("wrap.d_pc", 64'(mem_if.d_pc), 64'h3FFF_FFFF);
    tick(); check_latch("wrap", 30'h3FFF_FFFF, 32'h0);
    check("wrap.pc_plus1", 64'(if_id_pc_plus1), 64'd0);
    check("wrap.oob",      64'(oob_fetch),      64'd1);
    check("wrap.next_pc",  64'(mem_if.d_pc),    64'd0);
    check("wrap.fetched",  64'(perf_fetched),   64'd1);
    check("wrap.bubbles",  64'(perf_bubbles),   64'd1);
    tick(); check_latch("wrap0", 30'd0, 32'h2402_0005);
    check("wrap0.oob", 64'(oob_fetch), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core, directly upstream of the shared instruction/data memory stage.
- Owns the word-addressed PC and drives the memory's fetch address and port select.
- Latches the returned instruction into the IF/ID pipeline register.
- Handles hazard stalls, shared-port structural conflicts with the data path, and branch/jump redirects with one architectural delay slot.

Parameters:
- RESET_PC, 30'h0, word address loaded into the PC on reset.
- IMEM_DEPTH, 31, number of valid instruction words. A PC at or beyond this value fetches a NOP.

Ports:
- clk  input  1  single clock, all state rising-edge.
- rst  input  1  asynchronous, active-high reset.
- stall_in  input  1  hazard-unit stall (load-use); freezes PC and IF/ID.
- mem_busy  input  1  memory stage owns the shared port this cycle (load/store in MEM).
- redirect_valid  input  1  taken branch/jump resolved in EX.
- redirect_pc  input  30  target word address.
- fetch_select  output  1  memory port select: 1 = d_pc, 0 = data address.
- d_pc  output  30  current fetch word address (PC register).
- instr_in  input  32  combinational memory read data.
- if_id_valid  output  1  IF/ID holds a real instruction.
- if_id_instr  output  32  fetched instruction.
- if_id_pc  output  30  word address of if_id_instr.
- if_id_pc_plus1  output  30  if_id_pc + 1, used as the link address.
- oob_fetch  output  1  registered: the last latched fetch was out of range.
- perf_fetched  output  32  count of valid instructions latched.
- perf_bubbles  output  32  count of bubbles inserted.

Behaviour:
- Reset (async, immediate): PC = RESET_PC; IF/ID = bubble; oob_fetch = 0; both counters = 0.
- Bubble definition: valid = 0, instr = 32'h00000000 (sll $0,$0,0), pc = 0, pc_plus1 = 0.
- fetch_select = ~mem_busy, combinational. d_pc = PC register at all times.
- Effective instruction = instr_in if PC < IMEM_DEPTH, else 32'h0 with the oob flag set.
- Zero-latency memory: an instruction fetched in cycle N is visible on the if_id_* outputs in cycle N+1.
- Per-edge priority, highest first:
  1. redirect_valid:
     - PC <= redirect_pc.
     - If stall_in, IF/ID holds, so the delay slot in ID is kept.
     - Otherwise IF/ID <= bubble, which squashes branch+2; perf_bubbles += 1.
  2. stall_in: PC and IF/ID hold; no counter changes.
  3. mem_busy: PC holds (the instruction is re-fetched next cycle); IF/ID <= bubble; perf_bubbles += 1.
  4. Normal:
     - IF/ID <= {1, effective instr, PC, PC+1}; oob_fetch <= oob flag.
     - PC <= PC + 1; perf_fetched += 1.
- PC arithmetic is 30-bit and wraps 30'h3FFFFFFF -> 0. pc_plus1 wraps the same way.
- Counters wrap at 2^32 without saturating.
- Redirect is a single-cycle pulse. Redirect while mem_busy: PC still takes the target; IF/ID gets a bubble.
- Reset asserted mid-stall or mid-redirect: reset wins immediately; no partial update survives.
- oob_fetch holds its value during stall/bubble cycles; it updates only on a normal latch.

Decomposition:
- Shared package cpu_pkg (extend if it exists):
  - PC_W = 30, INSTR_W = 32, NOP_INSTR = 32'h0.
  - typedef if_id_t: struct {valid, instr, pc, pc_plus1}.
  - Bubble constant IF_ID_BUBBLE.
- Sub-module pc_reg: PC register with next-PC select (hold / +1 / redirect), async reset to RESET_PC.
- The IF/ID register and counters stay in fetch_stage.

Test Plan:
- Reset then run 4 cycles with memory words 0..3 = 24020005, 24030007, 24040002, 24050003:
  - if_id_pc must be 0, 1, 2, 3 with matching instrs and valid = 1.
  - perf_fetched = 4.
- mem_busy high for 2 cycles at PC = 5:
  - fetch_select = 0 in those cycles; two bubbles; PC stays 5.
  - Next latch is pc = 5; perf_bubbles = 2.
- stall_in for 3 cycles with IF/ID holding pc = 6 (instr 00623824):
  - Outputs stay unchanged; PC stays 7; counters unchanged.
- redirect_valid with redirect_pc = 2 while PC = 9:
  - Next cycle IF/ID is a bubble and d_pc = 2; the following latch is pc = 2, instr 24040002.
  - The delay slot latched before the redirect keeps its valid = 1.
- redirect_valid together with stall_in:
  - d_pc becomes the target; IF/ID holds; perf_bubbles unchanged.
- Run to PC = 31 (= IMEM_DEPTH): latched instr = 0, oob_fetch = 1, valid = 1.
- Assert rst asynchronously between clock edges during mem_busy:
  - PC = 0, if_id_valid = 0, counters = 0 before the next edge.
